// File: rtl/mem_load_driver.sv
// Byte-serial load engine: reads 1/2/4 bytes from the unified RAM port, assembles them
// little-endian, extends to 32 bits and presents the tagged result for one cycle.
module mem_load_driver #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pause,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_rd,
    input  logic [7:0]        mem_din,
    output logic [31:0]       data_out,
    output logic [TAG_W-1:0]  num_out
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic              sign;
    logic [TAG_W-1:0]  tag;
    logic [2:0]        cnt;
    logic [2:0]        nbytes;
    logic [1:0]        idx;
    logic [31:0]       bytes;
    logic [31:0]       ext;
    logic              accept;

    assign req_ready = (state == IDLE) && !pause && !rst;
    assign accept    = req_valid && req_ready && (req_tag != '0);

    // cnt counts issued addresses; the byte arriving now belongs to the previous issue
    assign idx = cnt[1:0] - 2'd1;

    always_comb begin
        nbytes = 3'd4;
        case (size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    always_comb begin
        ext = bytes;
        case (size)
            2'd0:    ext = {{24{sign & bytes[7]}}, bytes[7:0]};
            2'd1:    ext = {{16{sign & bytes[15]}}, bytes[15:0]};
            default: ext = bytes;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = READ;
            READ:    if (cnt == nbytes - 3'd1) state_next = WAIT;
            WAIT:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (!pause)
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            size     <= '0;
            sign     <= 1'b0;
            tag      <= '0;
            cnt      <= '0;
            bytes    <= '0;
            mem_a    <= '0;
            mem_rd   <= 1'b0;
            data_out <= '0;
            num_out  <= '0;
        end else if (!pause) begin
            case (state)
                IDLE: begin
                    num_out <= '0;
                    mem_rd  <= 1'b0;
                    if (accept) begin
                        addr  <= req_addr;
                        size  <= req_size;
                        sign  <= req_signed;
                        tag   <= req_tag;
                        cnt   <= '0;
                        bytes <= '0;
                    end
                end
                READ: begin
                    if (mem_rd)
                        bytes[{idx, 3'b000} +: 8] <= mem_din;
                    mem_a  <= (cnt == 3'd0) ? addr : mem_a + ADDR_W'(1);
                    mem_rd <= 1'b1;
                    cnt    <= cnt + 3'd1;
                end
                WAIT: begin
                    bytes[{idx, 3'b000} +: 8] <= mem_din;
                    mem_rd <= 1'b0;
                end
                DONE: begin
                    data_out <= ext;
                    num_out  <= tag;
                end
                default: ;
            endcase
        end
    end

endmodule
